// File: rtl/bcd_pkg.sv
// Shared constants, types and helpers for
// the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int DIG_W = 4;
  localparam logic [DIG_W-1:0] DIGIT_NINE = 4'h9;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_if.sv
// Start/busy/done handshake and result bus
// between the ADC sample register and the digit decoders.
interface bcd_if #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
);

  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out,
    input  overflow
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out,
    output overflow
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction cell:
// values 5..9 get +3 so the next shift carries correctly.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Adjust only 5..9, so the sum never leaves 4 bits.
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 converter, one bit per clock,
// with saturation to all nines when the input does not fit.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input logic clk,
  input logic rst,
  bcd_if.slave bus
);

  import bcd_pkg::*;

  localparam int BCD_W = DIG_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [63:0] MAX_VAL = 64'(pow10(DIGITS) - 1);

  state_t            state;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   adj;
  logic [SR_W-1:0]   sh;
  logic [CNT_W-1:0]  cnt;
  logic              ovf_pend;
  logic              ovf_cmp;
  logic              busy_q;
  logic              done_q;
  logic [BCD_W-1:0]  bcd_q;
  logic              ovf_q;

  assign ovf_cmp = 64'(bus.bin_in) > MAX_VAL;

  assign adj[BIN_W-1:0] = sr[BIN_W-1:0];

  genvar g;
  for (g = 0; g < DIGITS; g++) begin : g_dig
    bcd_add3 u_add3 (
      .din  (sr[BIN_W+DIG_W*g +: DIG_W]),
      .dout (adj[BIN_W+DIG_W*g +: DIG_W])
    );
  end

  assign sh = adj << 1;

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

  // Control FSM, datapath shift and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sr       <= {{BCD_W{1'b0}}, bus.bin_in};
            cnt      <= CNT_W'(BIN_W);
            ovf_pend <= ovf_cmp;
            busy_q   <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= sh;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            if (ovf_pend) begin
              bcd_q <= {DIGITS{DIGIT_NINE}};
            end else begin
              bcd_q <= sh[SR_W-1 -: BCD_W];
            end
            ovf_q  <= ovf_pend;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench: two converters (4 and 3 digits),
// directed vectors plus a reference-decoded sweep.
`timescale 1ns/1ps
module tb_bin_to_bcd_seq;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          due;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  exp_t q4[$];
  exp_t q3[$];
  logic prev4;
  logic prev3;

  bcd_if #(.BIN_W(12), .DIGITS(4)) i4 ();
  bcd_if #(.BIN_W(12), .DIGITS(3)) i3 ();

  bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4)) u4 (
    .clk (clk),
    .rst (rst),
    .bus (i4.slave)
  );

  bin_to_bcd_seq #(.BIN_W(12), .DIGITS(3)) u3 (
    .clk (clk),
    .rst (rst),
    .bus (i3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic logic [15:0] dec_ref(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    end
    return r;
  endfunction

  // Monitor for the 4-digit converter.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev4 = 1'b0;
    end else begin
      if (i4.done) begin
        check("d4_done_width", 64'(prev4), 64'd0);
        if (q4.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL d4_unexpected_done: got bcd %0h want none",
                   i4.bcd_out);
        end else begin
          e = q4.pop_front();
          check("d4_bcd", 64'(i4.bcd_out), 64'(e.bcd));
          check("d4_ovf", 64'(i4.overflow), 64'(e.ovf));
          check("d4_latency", 64'(cyc), 64'(e.due));
          for (int d = 0; d < 4; d++) begin
            check("d4_digit_le9",
                  64'(i4.bcd_out[4*d +: 4] > 4'd9), 64'd0);
          end
        end
      end
      prev4 = i4.done;
    end
  end

  // Monitor for the 3-digit converter.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev3 = 1'b0;
    end else begin
      if (i3.done) begin
        check("d3_done_width", 64'(prev3), 64'd0);
        if (q3.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL d3_unexpected_done: got bcd %0h want none",
                   i3.bcd_out);
        end else begin
          e = q3.pop_front();
          check("d3_bcd", 64'(i3.bcd_out), 64'(e.bcd));
          check("d3_ovf", 64'(i3.overflow), 64'(e.ovf));
          check("d3_latency", 64'(cyc), 64'(e.due));
        end
      end
      prev3 = i3.done;
    end
  end

  // Drive start for one edge; returns 1ns after the accepting edge.
  task automatic issue(input bit d3, input logic [11:0] v,
                       input logic [15:0] bcd, input bit ovf);
    exp_t e;
    if (d3) begin
      i3.start  = 1'b1;
      i3.bin_in = v;
    end else begin
      i4.start  = 1'b1;
      i4.bin_in = v;
    end
    @(posedge clk);
    #1;
    i3.start = 1'b0;
    i4.start = 1'b0;
    e.bcd = bcd;
    e.ovf = ovf;
    e.due = cyc + 12;
    if (d3) q3.push_back(e);
    else    q4.push_back(e);
  endtask

  task automatic finish_conv();
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    int v;
    cyc   = 0;
    n_cmp = 0;
    n_bad = 0;
    prev4 = 1'b0;
    prev3 = 1'b0;
    rst   = 1'b1;
    i4.start  = 1'b0;
    i4.bin_in = '0;
    i3.start  = 1'b0;
    i3.bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(i4.busy), 64'd0);
    check("rst_done", 64'(i4.done), 64'd0);
    check("rst_bcd", 64'(i4.bcd_out), 64'd0);
    check("rst_ovf", 64'(i4.overflow), 64'd0);
    check("rst3_bcd", 64'(i3.bcd_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero input: busy exactly 12 cycles, normal latency.
    issue(1'b0, 12'd0, 16'h0000, 1'b0);
    for (int i = 0; i < 11; i++) begin
      check("zero_busy_hi", 64'(i4.busy), 64'd1);
      @(posedge clk);
      #1;
    end
    check("zero_busy_hi", 64'(i4.busy), 64'd1);
    @(posedge clk);
    #1;
    check("zero_busy_lo", 64'(i4.busy), 64'd0);
    check("zero_done", 64'(i4.done), 64'd1);

    // Full scale, then back-to-back start in the done cycle.
    repeat (2) @(posedge clk);
    #1;
    issue(1'b0, 12'd4095, 16'h4095, 1'b0);
    finish_conv();
    issue(1'b0, 12'd1234, 16'h1234, 1'b0);
    finish_conv();
    check("hold_bcd", 64'(i4.bcd_out), 64'h1234);

    // Three-digit boundary and saturation.
    issue(1'b1, 12'd999, 16'h0999, 1'b0);
    finish_conv();
    issue(1'b1, 12'd1000, 16'h0999, 1'b1);
    finish_conv();
    repeat (5) @(posedge clk);
    #1;
    check("d3_ovf_hold", 64'(i3.overflow), 64'd1);
    issue(1'b1, 12'd7, 16'h0007, 1'b0);
    finish_conv();
    issue(1'b1, 12'd4095, 16'h0999, 1'b1);
    finish_conv();

    // Start while busy is ignored; bin_in change has no effect.
    issue(1'b0, 12'd250, 16'h0250, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    i4.start  = 1'b1;
    i4.bin_in = 12'd777;
    @(posedge clk);
    #1;
    i4.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    repeat (20) @(posedge clk);
    #1;

    // Asynchronous reset mid-conversion.
    issue(1'b0, 12'd3000, 16'h3000, 1'b0);
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    q4.delete();
    check("arst_busy", 64'(i4.busy), 64'd0);
    check("arst_done", 64'(i4.done), 64'd0);
    check("arst_bcd", 64'(i4.bcd_out), 64'd0);
    check("arst_ovf", 64'(i4.overflow), 64'd0);
    check("arst3_bcd", 64'(i3.bcd_out), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("arst_no_done", 64'(i4.bcd_out), 64'd0);
    issue(1'b0, 12'd42, 16'h0042, 1'b0);
    finish_conv();

    // Sweep with a decimal reference decode.
    for (int n = 0; n < 2000; n++) begin
      v = int'($urandom_range(0, 4095));
      issue(1'b0, 12'(v), dec_ref(v), 1'b0);
      finish_conv();
      if ((n % 97) == 0) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end

    // Drain the scoreboards with a bounded wait.
    for (int i = 0; i < 50; i++) begin
      if (q4.size() == 0 && q3.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check("drain_q4", 64'(q4.size()), 64'd0);
    check("drain_q3", 64'(q3.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits between the ADC sample register and the per-digit 7-segment decoders.
- Produces the packed BCD digits those decoders consume.
- Start/busy/done handshake; the result is held stable between conversions.

Parameters:
- BIN_W, 12, width of the unsigned binary input (ADC sample width).
- DIGITS, 4, number of BCD output digits; output width is 4*DIGITS.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request a conversion; sampled on posedge clk while idle.
- bin_in  input  BIN_W  unsigned value to convert; captured on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out/overflow update.
- bcd_out  output  4*DIGITS  packed BCD result, digit 0 (units) in bits [3:0].
- overflow  output  1  set with done when bin_in exceeded 10^DIGITS-1.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; busy=0, done=0, bcd_out=0, overflow=0; shift register and counter cleared.
- States: IDLE, SHIFT.
- IDLE:
  - done is deasserted (0) every cycle spent in IDLE.
  - start=1 at edge k: load shift register {4*DIGITS zeros, bin_in}, load counter=BIN_W, busy=1, go to SHIFT.
  - Compare bin_in > 10^DIGITS-1 at edge k (localparam constant); latch the result in an internal ovf_pend flag.
- SHIFT, each edge:
  - For every BCD digit field >= 5, add 3. This is combinational, applied before the shift.
  - Shift the whole register left by 1 and decrement the counter.
  - Final shift (counter==1):
    - bcd_out <= upper 4*DIGITS bits of the post-shift value, or all digits 4'h9 if ovf_pend.
    - overflow <= ovf_pend; done <= 1; busy <= 0; go to IDLE.
- Latency: start accepted at edge k; done high for exactly the one cycle following edge k+BIN_W.
- Throughput: the next start can be accepted at edge k+BIN_W+1, so one conversion per BIN_W+1 cycles.
- start while busy=1: ignored, no queuing, and bin_in changes do not affect the conversion in progress.
- start=1 during the done cycle: accepted (state is IDLE); done drops at that edge.
- bcd_out and overflow hold their last values until the next done; they never show intermediate values.
- Digit fields never exceed 9 at any output.
- bin_in=0 produces all-zero digits with normal latency; there is no early exit.
- rst mid-conversion: aborts immediately; no done pulse; outputs return to reset values.
- Adjust arithmetic is 4-bit per digit and cannot carry out of a digit, because the add happens only for values 5..9.
- If DIGITS is too small for BIN_W, correctness comes only from the saturation path.

Decomposition:
- Shared package bcd_pkg:
  - BCD digit width constant (4) and digit-nine constant 4'h9.
  - Function pow10(n) for the overflow threshold.
  - State enum {IDLE, SHIFT}.
- Sub-module bcd_add3: 4-bit combinational cell, out = (in >= 5) ? in+3 : in. Instantiate DIGITS copies via generate.
- The counter width is $clog2(BIN_W+1).

Test Plan:
- Default params, bin_in=0, start pulse at edge k → busy high for 12 cycles; done pulse after edge k+12; bcd_out=16'h0000; overflow=0.
- bin_in=12'd4095 → bcd_out=16'h4095 exactly 12 cycles after acceptance. Then bin_in=12'd1234, start in the done cycle → accepted; bcd_out=16'h1234 with a second done 13 cycles after the first.
- DIGITS=3, bin_in=12'd999 → bcd_out=12'h999, overflow=0.
  - bin_in=12'd1000 → bcd_out=12'h999, overflow=1 held until the next done.
  - A following bin_in=12'd7 conversion clears overflow and gives bcd_out=12'h007.
- bin_in=12'd250 started; at cycle k+5 drive start=1 with bin_in=12'd777 → ignored; result is 16'h0250, only one done pulse.
- bin_in=12'd3000 started; assert rst at k+6, asynchronously between edges → busy, done, bcd_out and overflow go to 0 immediately. No done follows; after release a fresh conversion of 12'd42 gives 16'h0042.
- Randomized sweep, 2000 values 0..4095: bcd_out matches the reference decimal decode. Every digit field is <= 9. Each done is exactly 1 cycle wide.
